hit_accumulator: RTL and testbench

Downstream consumer of the in-circle classifier stage. It accepts one `z` bit per `dav_`/`rfd` handshake, counts hits over a batch of `SAMPLES` points, then presents the hit count to the next consumer over a second `dav_`/`rfd` handshake. The counters then clear and the next batch starts. It is the Monte-Carlo accumulation stage of the π-estimation chain.

---
 rtl/hit_acc_pkg.sv | 25 ++
 rtl/hit_accumulator.sv | 123 ++++++++++++
 tb/tb_hit_accumulator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hit_acc_pkg.sv
// hit_acc_pkg: shared definitions for the hit_accumulator block.
//   state_e   - 2-bit handshake state encoding (WAIT/ACK/OUT/OUT_END)
//   PI_SHIFT  - left shift turning a hit count into a pi estimate
//   log2_of() - K = log2(SAMPLES) for power-of-two batch sizes
package hit_acc_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    ACK     = 2'd1,
    OUT     = 2'd2,
    OUT_END = 2'd3
  } state_e;

  // Circle of radius^2 < 4097 inside a 256x256 square: hit ratio is pi/16.
  localparam int PI_SHIFT = 4;

  function automatic int log2_of(input int n);
    int k;
    k = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) k = i + 1;
    return k;
  endfunction

endpackage

// File: rtl/hit_accumulator.sv
// hit_accumulator: Monte-Carlo accumulation stage of the pi-estimation chain.
// Accepts one z bit per dav_/rfd handshake, counts hits over SAMPLES points,
// then offers the count downstream over a second dav_/rfd handshake.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high
//   dav_in_   in   upstream data valid (active-low)
//   z_in      in   upstream in-circle flag
//   rfd_in    out  ready-for-data to upstream (active-high)
//   dav_out_  out  result valid to downstream (active-low)
//   rfd_out   in   downstream ready (active-high)
//   hits      out  hit count of the last completed batch
//   pi_q      out  hits << 4, only when HIT_ACC_PI_EST_EN is defined
//
// Optional feature macro: HIT_ACC_PI_EST_EN (adds the pi_q output/register).
module hit_accumulator
  import hit_acc_pkg::*;
#(
  parameter  int SAMPLES = 256,
  localparam int K       = log2_of(SAMPLES),
  parameter  int CW      = K + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dav_in_,
  input  logic          z_in,
  output logic          rfd_in,
  output logic          dav_out_,
  input  logic          rfd_out,
  output logic [CW-1:0] hits
`ifdef HIT_ACC_PI_EST_EN
  ,
  output logic [K+PI_SHIFT:0] pi_q
`endif
);

  localparam logic [K:0] FULL = (K+1)'(SAMPLES);

  state_e        state_q, state_d;
  logic [K:0]    smp_cnt_q, smp_cnt_d;
  logic [CW-1:0] hit_cnt_q, hit_cnt_d;
  logic [CW-1:0] hits_q, hits_d;
  logic          rfd_in_q, rfd_in_d;
  logic          dav_out_q, dav_out_d;

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    hit_cnt_d = hit_cnt_q;
    hits_d    = hits_q;
    case (state_q)
      WAIT: if (!dav_in_) begin
        hit_cnt_d = hit_cnt_q + CW'(z_in);
        smp_cnt_d = smp_cnt_q + (K+1)'(1);
        state_d   = ACK;
      end
      // Capture happened on entry; a long dav_in_ low just parks here.
      ACK: if (dav_in_) begin
        if (smp_cnt_q == FULL) begin
          state_d = OUT;
          hits_d  = hit_cnt_q;
        end else begin
          state_d = WAIT;
        end
      end
      OUT: if (!rfd_out) state_d = OUT_END;
      OUT_END: if (rfd_out) begin
        state_d   = WAIT;
        hit_cnt_d = '0;
        smp_cnt_d = '0;
      end
      default: state_d = WAIT;
    endcase
    // Outputs are decoded from the next state so they register at the
    // same edge as the state change.
    rfd_in_d  = (state_d == WAIT);
    dav_out_d = (state_d != OUT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= WAIT;
      smp_cnt_q <= '0;
      hit_cnt_q <= '0;
      hits_q    <= '0;
      rfd_in_q  <= 1'b1;
      dav_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      hit_cnt_q <= hit_cnt_d;
      hits_q    <= hits_d;
      rfd_in_q  <= rfd_in_d;
      dav_out_q <= dav_out_d;
    end
  end

  assign rfd_in   = rfd_in_q;
  assign dav_out_ = dav_out_q;
  assign hits     = hits_q;

`ifdef HIT_ACC_PI_EST_EN
  logic [K+PI_SHIFT:0] pi_q_q, pi_q_d;

  // Loads on the same edge as hits, from the same source.
  always_comb begin
    pi_q_d = pi_q_q;
    if (state_q == ACK && dav_in_ && smp_cnt_q == FULL)
      pi_q_d = (K+PI_SHIFT+1)'(hit_cnt_q) << PI_SHIFT;
  end

  always_ff @(posedge clock) begin
    if (reset) pi_q_q <= '0;
    else       pi_q_q <= pi_q_d;
  end

  assign pi_q = pi_q_q;
`else
  // Without the estimator there is no pi_q port or register.
`endif

endmodule

// File: tb/tb_hit_accumulator.sv
// Directed bench for hit_accumulator: a SAMPLES=4 instance (a) for the
// handshake/reset scenarios and a SAMPLES=256 instance (b) for the full-size
// random batch against a popcount model.
module tb_hit_accumulator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       dav_a_ = 1'b1, z_a = 1'b0, rfd_out_a = 1'b1;
  logic       rfd_in_a, dav_out_a_;
  logic [2:0] hits_a;
  logic       dav_b_ = 1'b1, z_b = 1'b0, rfd_out_b = 1'b1;
  logic       rfd_in_b, dav_out_b_;
  logic [8:0] hits_b;
`ifdef HIT_ACC_PI_EST_EN
  logic [6:0]  pi_a;
  logic [12:0] pi_b;
`endif

  hit_accumulator #(.SAMPLES(4)) dut_a (
    .clock(clock), .reset(reset), .dav_in_(dav_a_), .z_in(z_a),
    .rfd_in(rfd_in_a), .dav_out_(dav_out_a_), .rfd_out(rfd_out_a),
    .hits(hits_a)
`ifdef HIT_ACC_PI_EST_EN
    , .pi_q(pi_a)
`endif
  );

  hit_accumulator #(.SAMPLES(256)) dut_b (
    .clock(clock), .reset(reset), .dav_in_(dav_b_), .z_in(z_b),
    .rfd_in(rfd_in_b), .dav_out_(dav_out_b_), .rfd_out(rfd_out_b),
    .hits(hits_b)
`ifdef HIT_ACC_PI_EST_EN
    , .pi_q(pi_b)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen there too.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One prompt two-cycle handshake on instance a (b when sel_b).
  task automatic send(input bit sel_b, input logic z);
    if (sel_b) begin dav_b_ = 1'b0; z_b = z; end
    else       begin dav_a_ = 1'b0; z_a = z; end
    step();
    if (sel_b) dav_b_ = 1'b1; else dav_a_ = 1'b1;
    step();
  endtask

  // Drain one result from instance a with an immediate downstream.
  task automatic drain_a();
    rfd_out_a = 1'b0; step();
    rfd_out_a = 1'b1; step();
  endtask

  int pop;

  initial begin
    // Reset held 2 cycles
    step(2);
    reset = 1'b0;
    chk("rst_rfd_in", rfd_in_a, 1);
    chk("rst_dav_out", dav_out_a_, 1);
    chk("rst_hits", hits_a, 0);
`ifdef HIT_ACC_PI_EST_EN
    chk("rst_pi", pi_a, 0);
`endif

    // Mixed batch 1,0,1,1, first handshake checked edge by edge
    dav_a_ = 1'b0; z_a = 1'b1; step();
    chk("hs_rfd_fall", rfd_in_a, 0);
    dav_a_ = 1'b1; z_a = 1'b0; step();
    chk("hs_rfd_rise", rfd_in_a, 1);
    send(0, 0); send(0, 1);
    chk("mix_not_yet", dav_out_a_, 1);
    send(0, 1);
    chk("mix_dav_out", dav_out_a_, 0);
    chk("mix_hits", hits_a, 3);
    chk("mix_rfd_in", rfd_in_a, 0);
`ifdef HIT_ACC_PI_EST_EN
    chk("mix_pi", pi_a, 48);
`endif
    rfd_out_a = 1'b0; step();
    chk("out_end_dav", dav_out_a_, 1);
    chk("out_end_rfd_in", rfd_in_a, 0);
    rfd_out_a = 1'b1; step();
    chk("back_wait_rfd", rfd_in_a, 1);
    chk("hits_hold", hits_a, 3);

    // All hits, then all misses
    for (int i = 0; i < 4; i++) send(0, 1);
    chk("all1_hits", hits_a, 4);
`ifdef HIT_ACC_PI_EST_EN
    chk("all1_pi", pi_a, 64);
`endif
    drain_a();
    for (int i = 0; i < 4; i++) send(0, 0);
    chk("all0_dav_out", dav_out_a_, 0);
    chk("all0_hits", hits_a, 0);
    drain_a();

    // Long dav_in_: 5 cycles low counts once
    dav_a_ = 1'b0; z_a = 1'b1; step(5);
    chk("long_rfd_in", rfd_in_a, 0);
    dav_a_ = 1'b1; step();
    chk("long_back_wait", rfd_in_a, 1);
    chk("long_no_out", dav_out_a_, 1);
    send(0, 0); send(0, 0);
    chk("long_need3", dav_out_a_, 1);
    send(0, 0);
    chk("long_dav_out", dav_out_a_, 0);
    chk("long_hits", hits_a, 1);

    // Slow downstream with a stray upstream request in the window
    dav_a_ = 1'b0; z_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("slow_dav_out", dav_out_a_, 0);
      chk("slow_hits", hits_a, 1);
      chk("slow_rfd_in", rfd_in_a, 0);
    end
    dav_a_ = 1'b1;
    drain_a();
    for (int i = 0; i < 3; i++) send(0, 0);
    chk("stray_not_counted", dav_out_a_, 1);
    send(0, 0);
    chk("stray_batch_hits", hits_a, 0);
    drain_a();

    // Reset while in OUT
    for (int i = 0; i < 4; i++) send(0, 1);
    chk("pre_rst_dav_out", dav_out_a_, 0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_out_dav", dav_out_a_, 1);
    chk("rst_out_rfd", rfd_in_a, 1);
    chk("rst_out_hits", hits_a, 0);

    // Reset on a capture edge wins
    dav_a_ = 1'b0; z_a = 1'b1; reset = 1'b1; step();
    reset = 1'b0; dav_a_ = 1'b1;
    chk("rst_cap_rfd", rfd_in_a, 1);
    // Reset mid-batch discards the partial batch
    send(0, 1); send(0, 1);
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 1);
    chk("partial_discard", dav_out_a_, 1);
    send(0, 0);
    chk("partial_dav_out", dav_out_a_, 0);
    chk("partial_hits", hits_a, 3);
    drain_a();

    // SAMPLES=256 random stream against popcount
    pop = 0;
    for (int i = 0; i < 255; i++) begin
      logic z;
      z = 1'($urandom_range(0, 1));
      pop += int'(z);
      send(1, z);
    end
    chk("b255_no_out", dav_out_b_, 1);
    chk("b255_rfd_in", rfd_in_b, 1);
    begin
      logic z;
      z = 1'($urandom_range(0, 1));
      pop += int'(z);
      send(1, z);
    end
    chk("b256_dav_out", dav_out_b_, 0);
    chk("b256_hits", hits_b, pop);
`ifdef HIT_ACC_PI_EST_EN
    chk("b256_pi", pi_b, pop * 16);
`endif
    chk("b256_rfd_in", rfd_in_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
